// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse host.
//   CMD_ENABLE / RSP_ACK : Enable-Data-Reporting command and its acknowledge.
//   host_state_t         : host sequencer state (also exported for observation).
//   B0_*                 : bit positions inside the first byte of a stream packet.
package ps2_pkg;

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  // First packet byte layout; bits [2:0] are the buttons {middle, right, left}.
  localparam int B0_SYNC  = 3;
  localparam int B0_XSIGN = 4;
  localparam int B0_YSIGN = 5;
  localparam int B0_XOVF  = 6;
  localparam int B0_YOVF  = 7;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SEND    = 3'd3,
    ST_DEV_ACK = 3'd4,
    ST_WAIT_FA = 3'd5,
    ST_STREAM  = 3'd6
  } host_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and device-to-host frame receiver.
//   clk_25, clr        : clock, asynchronous active-high reset
//   ps2c_i, ps2d_i     : raw line levels
//   rx_en              : receive frames; when low the bit counter is held at 0
//   tmo_arm            : enable the clock-high watchdog
//   fclk_fall          : one-cycle pulse on a falling edge of the filtered clock
//   fdat               : filtered data level
//   mid_frame          : at least one bit of the current frame has been taken
//   rx_byte/byte_valid : good frame payload, valid for one cycle
//   frame_err          : one-cycle pulse on bad start/parity/stop or watchdog expiry
// The byte interface has no back-pressure: byte_valid and frame_err are
// mutually exclusive single-cycle strobes the consumer must take when seen.
module ps2_frame_rx
  #(parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000)
  (input  logic       clk_25,
   input  logic       clr,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   input  logic       rx_en,
   input  logic       tmo_arm,
   output logic       fclk_fall,
   output logic       fdat,
   output logic       mid_frame,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [FILT_LEN-1:0] c_sr, d_sr;
  logic                fclk, fclk_d;
  logic [3:0]          bit_cnt;
  logic [9:0]          sh;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic                frame_ok;

  assign fclk_fall = fclk_d & ~fclk;
  assign mid_frame = (bit_cnt != 4'd0);
  assign tmo_hit   = tmo_arm & fclk & (tmo_cnt == TMO_LAST);

  // At the stop-bit fall sh holds start (bit 0), data (8:1) and parity (9).
  assign frame_ok  = ~sh[0] & fdat & (^sh[9:1]);

  // Glitch filter: the filtered level only moves once every tap agrees.
  always_ff @(posedge clk_25 or posedge clr) begin
    if (clr) begin
      c_sr   <= '1;
      d_sr   <= '1;
      fclk   <= 1'b1;
      fdat   <= 1'b1;
      fclk_d <= 1'b1;
    end else begin
      c_sr   <= {c_sr[FILT_LEN-2:0], ps2c_i};
      d_sr   <= {d_sr[FILT_LEN-2:0], ps2d_i};
      fclk_d <= fclk;
      if (&c_sr)       fclk <= 1'b1;
      else if (~|c_sr) fclk <= 1'b0;
      if (&d_sr)       fdat <= 1'b1;
      else if (~|d_sr) fdat <= 1'b0;
    end
  end

  // Watchdog counts consecutive filtered-clock-high cycles while armed.
  always_ff @(posedge clk_25 or posedge clr) begin
    if (clr)                           tmo_cnt <= '0;
    else if (!tmo_arm || !fclk || tmo_hit) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk_25 or posedge clr) begin
    if (clr) begin
      bit_cnt    <= 4'd0;
      sh         <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tmo_hit) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end else if (!rx_en) begin
        bit_cnt <= 4'd0;
      end else if (fclk_fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            rx_byte    <= sh[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          sh      <= {fdat, sh[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_host.sv
// PS/2 mouse host: sends Enable-Data-Reporting, waits for the acknowledge,
// then decodes 3-byte stream packets into buttons, deltas and a cursor
// position clamped to [0, X_MAX] x [0, Y_MAX].
//   clk_25, clr        : clock, asynchronous active-high reset
//   ps2c_i, ps2d_i     : raw line levels
//   ps2c_oe, ps2d_oe   : pull the line low when 1
//   ready              : acknowledge received, stream decoding active
//   buttons, dx, dy    : fields of the last good packet (dx/dy raw 9-bit signed)
//   x_pos, y_pos       : accumulated cursor position
//   pkt_valid          : one-cycle strobe when the packet outputs update
//   err                : sticky fault flag, cleared by the next pkt_valid
//   fsm_state          : current host sequencer state
module ps2_mouse_host
  import ps2_pkg::*;
  #(parameter int FILT_LEN    = 8,
    parameter int INHIBIT_CYC = 2500,
    parameter int TIMEOUT_CYC = 50000,
    parameter int POS_W       = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479)
  (input  logic             clk_25,
   input  logic             clr,
   input  logic             ps2c_i,
   input  logic             ps2d_i,
   output logic             ps2c_oe,
   output logic             ps2d_oe,
   output logic             ready,
   output logic [2:0]       buttons,
   output logic [8:0]       dx,
   output logic [8:0]       dy,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic             pkt_valid,
   output logic             err,
   output host_state_t      fsm_state);

  localparam int AW = POS_W + 2;
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam logic [IW-1:0]    INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [POS_W-1:0] X_LIM    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM    = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] X_HOME   = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0] Y_HOME   = POS_W'(Y_MAX / 2);

  host_state_t state, state_nx;
  logic [IW-1:0]  inh_cnt;
  logic [10:0]    tx_sh;
  logic [3:0]     tx_cnt;
  logic [1:0]     byte_idx;
  logic [2:0]     b0_btn;
  logic           b0_xs, b0_ys, b0_xo, b0_yo;
  logic [7:0]     b1;
  logic           rx_en, tmo_arm;
  logic           fclk_fall, fdat, mid_frame, byte_valid, frame_err;
  logic [7:0]     rx_byte;
  logic signed [AW-1:0] dx_acc, dy_acc, x_sum, y_sum;
  logic [POS_W-1:0]     x_next, y_next;

  assign fsm_state = state;

  ps2_frame_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk_25     (clk_25),
    .clr        (clr),
    .ps2c_i     (ps2c_i),
    .ps2d_i     (ps2d_i),
    .rx_en      (rx_en),
    .tmo_arm    (tmo_arm),
    .fclk_fall  (fclk_fall),
    .fdat       (fdat),
    .mid_frame  (mid_frame),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  function automatic logic [POS_W-1:0] clamp(input logic signed [AW-1:0] v,
                                             input logic [POS_W-1:0]     hi);
    if (v[AW-1])                      return '0;
    else if (v > $signed({2'b00, hi})) return hi;
    else                              return v[POS_W-1:0];
  endfunction

  // Overflowed axes contribute nothing; screen y grows downward.
  always_comb begin
    dx_acc = b0_xo ? '0 : {{(AW-9){b0_xs}}, b0_xs, b1};
    dy_acc = b0_yo ? '0 : {{(AW-9){b0_ys}}, b0_ys, rx_byte};
    x_sum  = $signed({2'b00, x_pos}) + dx_acc;
    y_sum  = $signed({2'b00, y_pos}) - dy_acc;
    x_next = clamp(x_sum, X_LIM);
    y_next = clamp(y_sum, Y_LIM);
  end

  always_comb begin
    state_nx = state;
    ps2c_oe  = 1'b0;
    ps2d_oe  = 1'b0;
    rx_en    = 1'b0;
    tmo_arm  = 1'b0;
    unique case (state)
      ST_RESET:   state_nx = ST_INHIBIT;
      ST_INHIBIT: begin
        ps2c_oe = 1'b1;
        if (inh_cnt == INH_LAST) state_nx = ST_REQ;
      end
      // Data low with clock released is the request-to-send (start bit).
      ST_REQ: begin
        ps2d_oe  = 1'b1;
        state_nx = ST_SEND;
      end
      ST_SEND: begin
        ps2d_oe = ~tx_sh[0];
        tmo_arm = 1'b1;
        if (frame_err)                        state_nx = ST_INHIBIT;
        else if (fclk_fall && tx_cnt == 4'd9) state_nx = ST_DEV_ACK;
      end
      ST_DEV_ACK: begin
        tmo_arm = 1'b1;
        if (frame_err)              state_nx = ST_INHIBIT;
        else if (fclk_fall && !fdat) state_nx = ST_WAIT_FA;
      end
      ST_WAIT_FA: begin
        rx_en   = 1'b1;
        tmo_arm = 1'b1;
        if (frame_err)       state_nx = ST_INHIBIT;
        else if (byte_valid) state_nx = (rx_byte == RSP_ACK) ? ST_STREAM : ST_INHIBIT;
      end
      ST_STREAM: begin
        rx_en   = 1'b1;
        tmo_arm = mid_frame | (byte_idx != 2'd0);
      end
      default: state_nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_25 or posedge clr) begin
    if (clr) begin
      state     <= ST_RESET;
      inh_cnt   <= '0;
      tx_sh     <= '1;
      tx_cnt    <= 4'd0;
      byte_idx  <= 2'd0;
      b0_btn    <= 3'd0;
      b0_xs     <= 1'b0;
      b0_ys     <= 1'b0;
      b0_xo     <= 1'b0;
      b0_yo     <= 1'b0;
      b1        <= 8'h00;
      ready     <= 1'b0;
      buttons   <= 3'd0;
      dx        <= 9'd0;
      dy        <= 9'd0;
      x_pos     <= X_HOME;
      y_pos     <= Y_HOME;
      pkt_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      pkt_valid <= 1'b0;
      inh_cnt   <= (state == ST_INHIBIT) ? inh_cnt + 1'b1 : '0;

      // Bit 0 is the start bit already on the line; each device fall moves on.
      if (state == ST_REQ) begin
        tx_sh  <= {1'b1, ~^CMD_ENABLE, CMD_ENABLE, 1'b0};
        tx_cnt <= 4'd0;
      end else if (state == ST_SEND && fclk_fall) begin
        tx_sh  <= {1'b1, tx_sh[10:1]};
        tx_cnt <= tx_cnt + 4'd1;
      end

      if (state == ST_WAIT_FA && byte_valid && rx_byte == RSP_ACK) ready <= 1'b1;

      if (frame_err) begin
        err      <= 1'b1;
        byte_idx <= 2'd0;
      end else if (state == ST_STREAM && byte_valid) begin
        unique case (byte_idx)
          2'd0: begin
            // Without the sync bit this cannot be a first byte: stay aligned at 0.
            if (rx_byte[B0_SYNC]) begin
              b0_btn   <= rx_byte[2:0];
              b0_xs    <= rx_byte[B0_XSIGN];
              b0_ys    <= rx_byte[B0_YSIGN];
              b0_xo    <= rx_byte[B0_XOVF];
              b0_yo    <= rx_byte[B0_YOVF];
              byte_idx <= 2'd1;
            end
          end
          2'd1: begin
            b1       <= rx_byte;
            byte_idx <= 2'd2;
          end
          default: begin
            byte_idx  <= 2'd0;
            buttons   <= b0_btn;
            dx        <= {b0_xs, b1};
            dy        <= {b0_ys, rx_byte};
            x_pos     <= x_next;
            y_pos     <= y_next;
            pkt_valid <= 1'b1;
            err       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
